local_out_port_buffer: RTL

Local output port buffer of a mesh router. It sits between the router crossbar and the PE collector: it accepts packets routed to the local PE, queues them in a small FIFO, and delivers them one at a time over the two-phase Req/Gnt handshake the collector implements. It also provides back-pressure to the crossbar and a delivered-packet counter for simulation statistics.

---
 rtl/local_out_port_buffer_pkg.sv | 21 ++
 rtl/local_out_port_buffer_fifo.sv | 72 +++++++
 rtl/local_out_port_buffer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/local_out_port_buffer_pkg.sv
// ---------------------------------------------------------------------------
// local_out_port_buffer_pkg
// Shared definitions for the local output port of a mesh router:
//   - delivery FSM state encoding (also exposed on the debug port)
//   - packet field offsets, shared with the packet generator and collector
// ---------------------------------------------------------------------------
package local_out_port_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,  // no request outstanding
      ST_REQ     = 2'd1,  // ReqDnStr high, waiting for the collector grant
      ST_RELEASE = 2'd2   // packet handed over, waiting for the grant to drop
   } dlv_state_t;

   // Packet layout: [15:6] PacketID, [5:0] SenderID. The buffer never
   // looks inside a packet; these are here so every block agrees on them.
   localparam int PACKET_ID_MSB   = 15;
   localparam int PACKET_ID_LSB   = 6;
   localparam int SENDER_ID_WIDTH = 6;

endpackage

// File: rtl/local_out_port_buffer_fifo.sv
// ---------------------------------------------------------------------------
// local_fifo
// Parameterized circular buffer. Pointers are log2(DEPTH) bits and wrap
// naturally, so DEPTH must be a power of two. Push while full and pop while
// empty are ignored. Full/empty come from the registered count, so a push
// in the same cycle as a pop on a full buffer is still refused.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write request and data
//   pop          remove the head entry
//   head         current head entry (combinational read of storage)
//   count        number of stored entries (0..DEPTH)
//   full, empty  count == DEPTH / count == 0
// ---------------------------------------------------------------------------
module local_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage has no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/local_out_port_buffer.sv
// ---------------------------------------------------------------------------
// local_out_port_buffer
// Local output port of a mesh router: queues packets from the crossbar in a
// small FIFO and hands them one at a time to the PE collector.
//
// Handshakes:
//   Upstream   - the crossbar offers one packet per cycle with ReqUpStr
//                high; it is accepted on that edge iff the FIFO is not full
//                (full judged before any pop in the same cycle). GntUpStr
//                pulses for one cycle after each accepted write. UpStrFull
//                is registered and is high exactly while the FIFO holds
//                bufDepth packets.
//   Downstream - two-phase Req/Gnt. ReqDnStr rises with PacketOut already
//                stable, and both hold until GntDnStr is seen high; the head
//                is popped on that edge and ReqDnStr drops. The next request
//                is not raised until GntDnStr has returned low. DnStrFull
//                only gates raising a new request; an outstanding request is
//                never withdrawn.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   PacketIn, ReqUpStr     packet and write request from the crossbar
//   GntUpStr, UpStrFull    write acknowledge pulse, FIFO full flag
//   PacketOut, ReqDnStr    registered head packet and request to collector
//   GntDnStr, DnStrFull    collector grant and collector-full flag
//   DelivCount             packets delivered since reset (wraps at 2^32)
//   dbg_state, dbg_count   delivery FSM state and FIFO occupancy
//   dbg_router_id          routerID tag of this instance
// ---------------------------------------------------------------------------
module local_out_port_buffer
   import local_out_port_buffer_pkg::*;
#(
   parameter logic [5:0] routerID  = 6'b000_000,
   parameter int         dataWidth = 32,
   parameter int         bufDepth  = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [dataWidth-1:0]        PacketIn,
   input  logic                        ReqUpStr,
   output logic                        GntUpStr,
   output logic                        UpStrFull,
   output logic [dataWidth-1:0]        PacketOut,
   output logic                        ReqDnStr,
   input  logic                        GntDnStr,
   input  logic                        DnStrFull,
   output logic [31:0]                 DelivCount,
   output dlv_state_t                  dbg_state,
   output logic [$clog2(bufDepth):0]   dbg_count,
   output logic [5:0]                  dbg_router_id
);

   localparam int AW = $clog2(bufDepth);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(bufDepth);

   logic [dataWidth-1:0] head;
   logic [AW:0]          fifo_count;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push_ok;
   logic                 full_next;
   logic                 pop_now;
   logic                 load_out;
   dlv_state_t           state;
   dlv_state_t           state_next;

   local_fifo #(
      .WIDTH (dataWidth),
      .DEPTH (bufDepth)
   ) u_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (ReqUpStr),
      .din   (PacketIn),
      .pop   (pop_now),
      .head  (head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign push_ok = ReqUpStr && !fifo_full;

   // FIFO is full after this edge if it was full and nothing leaves, or if
   // it holds one less than full and this write gets in with no pop.
   assign full_next = !pop_now &&
                      (fifo_full || (push_ok && (fifo_count == FULL_CNT - 1'b1)));

   // Delivery FSM: next state and strobes.
   always_comb begin
      state_next = state;
      load_out   = 1'b0;
      pop_now    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty && !DnStrFull) begin
               load_out   = 1'b1;
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (GntDnStr) begin
               pop_now    = 1'b1;
               state_next = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!GntDnStr) begin
               if (!fifo_empty && !DnStrFull) begin
                  load_out   = 1'b1;
                  state_next = ST_REQ;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ReqDnStr is a register so it drops immediately on asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         ReqDnStr   <= 1'b0;
         PacketOut  <= '0;
         DelivCount <= '0;
         GntUpStr   <= 1'b0;
         UpStrFull  <= 1'b0;
      end else begin
         state     <= state_next;
         ReqDnStr  <= (state_next == ST_REQ);
         GntUpStr  <= push_ok;
         UpStrFull <= full_next;
         if (load_out) begin
            PacketOut <= head;
         end
         if (pop_now) begin
            DelivCount <= DelivCount + 32'd1;
         end
      end
   end

   assign dbg_state     = state;
   assign dbg_count     = fifo_count;
   assign dbg_router_id = routerID;

endmodule
